// File: rtl/dp_mem_responder_if.sv
// dp_mem_responder_if
// Bundles the datapath <-> memory request/response signals of the
// datapath cache interface.
//   master : datapath side (drives requests, halt; receives hits, loads, flushed)
//   slave  : memory responder side (the reverse)
// Signals:
//   imemREN/imemaddr          instruction fetch request and byte address
//   ihit/imemload             instruction response strobe and word
//   dmemREN/dmemWEN/datomic   data read / write request, LL/SC qualifier
//   dmemaddr/dmemstore        data byte address and store data
//   dhit/dmemload             data response strobe and load / SC result
//   halt/flushed              datapath halted / responder drained (sticky)
interface dp_mem_responder_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        dmemREN;
  logic        dmemWEN;
  logic        datomic;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        dhit;
  logic [31:0] dmemload;
  logic        halt;
  logic        flushed;

  modport master (
    output imemREN, imemaddr, dmemREN, dmemWEN, datomic, dmemaddr, dmemstore, halt,
    input  ihit, imemload, dhit, dmemload, flushed
  );

  modport slave (
    input  imemREN, imemaddr, dmemREN, dmemWEN, datomic, dmemaddr, dmemstore, halt,
    output ihit, imemload, dhit, dmemload, flushed
  );
endinterface

// File: rtl/dp_mem_responder.sv
// dp_mem_responder
// Memory-side responder standing in for the cache hierarchy during pipeline
// bring-up. Instruction fetches and data loads/stores are served one at a
// time from a single-ported word memory after a fixed latency of LAT wait
// cycles; hit strobes last one cycle and load data holds until the next
// access of the same port. Data requests win over instruction requests.
// Ports:
//   CLK  : clock, all state changes on the rising edge
//   RST  : synchronous active-high reset (memory contents are kept)
//   bus  : dp_mem_responder_if.slave (requests in, hits/loads/flushed out)
// Parameters:
//   DEPTH_WORDS : memory size in 32-bit words, power of two
//   LAT         : wait cycles between acceptance and response, 1..15
// Optional feature macro:
//   DP_MEM_LLSC_EN : load-linked / store-conditional support via datomic.
//                    Undefined: datomic is ignored, all writes unconditional.
module dp_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LAT         = 2
) (
  input logic               CLK,
  input logic               RST,
  dp_mem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    IWAIT = 3'd1,
    DWAIT = 3'd2,
    IRESP = 3'd3,
    DRESP = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          wr_q, wr_d;
  logic [31:0]   imemload_q;
  logic [31:0]   dmemload_q;
  logic          flushed_q;
  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          dreq;
  logic          i_acc;
  logic          d_acc;
  logic          mem_we;
  logic [31:0]   wr_result;

  assign dreq  = bus.dmemREN | bus.dmemWEN;
  // The single memory access of a transaction happens on the WAIT->RESP edge.
  assign i_acc = (state_q == IWAIT) && (cnt_q == 4'd0);
  assign d_acc = (state_q == DWAIT) && (cnt_q == 4'd0);

  // ---- transaction FSM: next state and request capture ----
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    unique case (state_q)
      IDLE: begin
        if (dreq) begin
          state_d = DWAIT;
          cnt_d   = 4'(LAT - 1);
          idx_d   = bus.dmemaddr[AW+1:2];
          wdata_d = bus.dmemstore;
          wr_d    = bus.dmemWEN;
        end else if (bus.imemREN && !bus.halt) begin
          state_d = IWAIT;
          cnt_d   = 4'(LAT - 1);
          idx_d   = bus.imemaddr[AW+1:2];
          wr_d    = 1'b0;
        end
      end
      IWAIT: begin
        if (cnt_q == 4'd0) state_d = IRESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      DWAIT: begin
        if (cnt_q == 4'd0) state_d = DRESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      IRESP:   state_d = IDLE;
      DRESP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      flushed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Drained: idle, halted, and nothing left for the data port to do.
      if ((state_q == IDLE) && bus.halt && !dreq) flushed_q <= 1'b1;
    end
  end

  // Captured request payload is data, not control: no reset needed.
  always_ff @(posedge CLK) begin
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
    wr_q    <= wr_d;
  end

  // ---- link register and write qualification ----
`ifdef DP_MEM_LLSC_EN
  logic          atomic_q;
  logic          link_vld_q;
  logic [AW-1:0] link_idx_q;
  logic          sc_ok;
  logic          unused_bits;

  assign sc_ok = link_vld_q && (link_idx_q == idx_q);

  always_ff @(posedge CLK) begin
    if ((state_q == IDLE) && dreq) atomic_q <= bus.datomic;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      link_vld_q <= 1'b0;
    end else if (d_acc) begin
      if (!wr_q && atomic_q) begin
        link_vld_q <= 1'b1;
        link_idx_q <= idx_q;
      end else if (wr_q && atomic_q) begin
        link_vld_q <= 1'b0;
      end else if (wr_q && (idx_q == link_idx_q)) begin
        link_vld_q <= 1'b0;
      end
    end
  end

  // A failed SC leaves the array untouched.
  assign mem_we    = d_acc && wr_q && !RST && (!atomic_q || sc_ok);
  assign wr_result = atomic_q ? {31'd0, sc_ok} : 32'd0;

  assign unused_bits = ^{bus.imemaddr[31:AW+2], bus.imemaddr[1:0],
                         bus.dmemaddr[31:AW+2], bus.dmemaddr[1:0]};
`else
  logic unused_bits;

  // RST gating keeps a write abandoned by reset from landing on the access edge.
  assign mem_we    = d_acc && wr_q && !RST;
  assign wr_result = 32'd0;

  assign unused_bits = ^{bus.imemaddr[31:AW+2], bus.imemaddr[1:0],
                         bus.dmemaddr[31:AW+2], bus.dmemaddr[1:0], bus.datomic};
`endif

  // ---- memory access stage: array write and registered load data ----
  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[idx_q] <= wdata_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      imemload_q <= 32'd0;
      dmemload_q <= 32'd0;
    end else begin
      if (i_acc) imemload_q <= mem_q[idx_q];
      if (d_acc) dmemload_q <= wr_q ? wr_result : mem_q[idx_q];
    end
  end

  // ---- response outputs ----
  assign bus.ihit     = (state_q == IRESP);
  assign bus.dhit     = (state_q == DRESP);
  assign bus.imemload = imemload_q;
  assign bus.dmemload = dmemload_q;
  assign bus.flushed  = flushed_q;

endmodule

// File: tb/tb_dp_mem_responder.sv
module tb_dp_mem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   overlaps;

  dp_mem_responder_if bus ();

  dp_mem_responder #(
    .DEPTH_WORDS(DEPTH),
    .LAT        (LAT)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.ihit === 1'b1 && bus.dhit === 1'b1) overlaps++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.imemREN   = 1'b0;
    bus.imemaddr  = 32'd0;
    bus.dmemREN   = 1'b0;
    bus.dmemWEN   = 1'b0;
    bus.datomic   = 1'b0;
    bus.dmemaddr  = 32'd0;
    bus.dmemstore = 32'd0;
    bus.halt      = 1'b0;
  endtask

  // One data transaction from IDLE; returns cycles to dhit (-1 if none) and load.
  task automatic data_txn(input logic wen, input logic atomic, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output logic [31:0] ld);
    bus.dmemREN   = ~wen;
    bus.dmemWEN   = wen;
    bus.datomic   = atomic;
    bus.dmemaddr  = addr;
    bus.dmemstore = wdata;
    tick();
    bus.dmemREN = 1'b0;
    bus.dmemWEN = 1'b0;
    bus.datomic = 1'b0;
    lat = -1;
    ld  = 32'hx;
    for (int n = 1; n <= 20 && lat < 0; n++) begin
      if (bus.dhit === 1'b1) begin
        lat = n;
        ld  = bus.dmemload;
      end
      tick();
    end
  endtask

  task automatic fetch_txn(input logic [31:0] addr, output int lat, output logic [31:0] ld);
    bus.imemREN  = 1'b1;
    bus.imemaddr = addr;
    tick();
    bus.imemREN = 1'b0;
    lat = -1;
    ld  = 32'hx;
    for (int n = 1; n <= 20 && lat < 0; n++) begin
      if (bus.ihit === 1'b1) begin
        lat = n;
        ld  = bus.imemload;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    int          lat;
    logic [31:0] ld;
    rst           = 1'b1;
    bus.imemREN   = 1'b1;
    bus.dmemREN   = 1'b1;
    bus.dmemWEN   = 1'b1;
    bus.halt      = 1'b1;
    bus.imemaddr  = 32'h4;
    bus.dmemaddr  = 32'h8;
    bus.dmemstore = 32'hFFFF_0000;
    tick();
    tick();
    checks++; if (bus.ihit !== 1'b0) begin failures++; $display("FAIL reset_ihit got=%b exp=0", bus.ihit); end
    checks++; if (bus.dhit !== 1'b0) begin failures++; $display("FAIL reset_dhit got=%b exp=0", bus.dhit); end
    checks++; if (bus.flushed !== 1'b0) begin failures++; $display("FAIL reset_flushed got=%b exp=0", bus.flushed); end
    checks++; if (bus.imemload !== 32'd0) begin failures++; $display("FAIL reset_imemload got=%h exp=0", bus.imemload); end
    checks++; if (bus.dmemload !== 32'd0) begin failures++; $display("FAIL reset_dmemload got=%h exp=0", bus.dmemload); end
    idle_inputs();
    rst = 1'b0;
    fetch_txn(32'h0, lat, ld);
    checks++; if (lat !== LAT + 1) begin failures++; $display("FAIL reset_first_fetch_latency got=%0d exp=%0d", lat, LAT + 1); end
  endtask

  task automatic test_write_fetch();
    int          lat;
    logic [31:0] ld;
    data_txn(1'b1, 1'b0, 32'h40, 32'hDEADBEEF, lat, ld);
    checks++; if (lat !== LAT + 1) begin failures++; $display("FAIL write_latency got=%0d exp=%0d", lat, LAT + 1); end
    checks++; if (ld !== 32'd0) begin failures++; $display("FAIL write_dmemload got=%h exp=0", ld); end
    fetch_txn(32'h40, lat, ld);
    checks++; if (lat !== LAT + 1) begin failures++; $display("FAIL fetch_latency got=%0d exp=%0d", lat, LAT + 1); end
    checks++; if (ld !== 32'hDEADBEEF) begin failures++; $display("FAIL fetch_after_write got=%h exp=deadbeef", ld); end
    checks++; if (bus.ihit !== 1'b0) begin failures++; $display("FAIL ihit_one_cycle got=%b exp=0", bus.ihit); end
    checks++; if (bus.imemload !== 32'hDEADBEEF) begin failures++; $display("FAIL imemload_hold got=%h exp=deadbeef", bus.imemload); end
    fetch_txn(32'h40 + 4 * DEPTH + 32'h3, lat, ld);
    checks++; if (ld !== 32'hDEADBEEF) begin failures++; $display("FAIL fetch_alias got=%h exp=deadbeef", ld); end
    data_txn(1'b0, 1'b0, 32'h40, 32'd0, lat, ld);
    checks++; if (ld !== 32'hDEADBEEF) begin failures++; $display("FAIL data_read got=%h exp=deadbeef", ld); end
  endtask

  task automatic test_priority();
    int          lat, d_at, i_at;
    logic [31:0] ld, dl, il;
    data_txn(1'b1, 1'b0, 32'h0, 32'h1111_1111, lat, ld);
    d_at = -1;
    i_at = -1;
    dl   = 32'hx;
    il   = 32'hx;
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0;
    bus.dmemREN  = 1'b1;
    bus.dmemaddr = 32'h40;
    tick();
    bus.dmemREN = 1'b0;
    for (int n = 1; n <= 30 && i_at < 0; n++) begin
      if (bus.dhit === 1'b1 && d_at < 0) begin d_at = n; dl = bus.dmemload; end
      if (bus.ihit === 1'b1) begin i_at = n; il = bus.imemload; bus.imemREN = 1'b0; end
      if (d_at > 0 && n == d_at + 2) bus.imemREN = 1'b0;
      tick();
    end
    bus.imemREN = 1'b0;
    checks++; if (d_at !== LAT + 1) begin failures++; $display("FAIL prio_dhit_cycle got=%0d exp=%0d", d_at, LAT + 1); end
    checks++; if (i_at !== 2 * LAT + 3) begin failures++; $display("FAIL prio_ihit_cycle got=%0d exp=%0d", i_at, 2 * LAT + 3); end
    checks++; if (dl !== 32'hDEADBEEF) begin failures++; $display("FAIL prio_dmemload got=%h exp=deadbeef", dl); end
    checks++; if (il !== 32'h1111_1111) begin failures++; $display("FAIL prio_imemload got=%h exp=11111111", il); end
  endtask

  task automatic test_no_preempt();
    int          lat, d_at, i_at;
    logic [31:0] ld, il;
    d_at = -1;
    i_at = -1;
    il   = 32'hx;
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0;
    tick();
    bus.imemREN   = 1'b0;
    bus.dmemWEN   = 1'b1;
    bus.dmemaddr  = 32'h0;
    bus.dmemstore = 32'h2222_2222;
    for (int n = 1; n <= 30 && d_at < 0; n++) begin
      if (bus.ihit === 1'b1) begin i_at = n; il = bus.imemload; end
      if (bus.dhit === 1'b1) begin d_at = n; bus.dmemWEN = 1'b0; end
      if (i_at > 0 && n == i_at + 2) bus.dmemWEN = 1'b0;
      tick();
    end
    bus.dmemWEN = 1'b0;
    checks++; if (i_at !== LAT + 1) begin failures++; $display("FAIL nopre_ihit_cycle got=%0d exp=%0d", i_at, LAT + 1); end
    checks++; if (d_at !== 2 * LAT + 3) begin failures++; $display("FAIL nopre_dhit_cycle got=%0d exp=%0d", d_at, 2 * LAT + 3); end
    checks++; if (il !== 32'h1111_1111) begin failures++; $display("FAIL nopre_old_word got=%h exp=11111111", il); end
    fetch_txn(32'h0, lat, ld);
    checks++; if (ld !== 32'h2222_2222) begin failures++; $display("FAIL nopre_new_word got=%h exp=22222222", ld); end
  endtask

  task automatic test_back_to_back();
    int first, second;
    first  = -1;
    second = -1;
    bus.dmemREN  = 1'b1;
    bus.dmemaddr = 32'h40;
    tick();
    for (int n = 1; n <= 30 && second < 0; n++) begin
      if (bus.dhit === 1'b1) begin
        if (first < 0) first = n;
        else begin second = n; bus.dmemREN = 1'b0; end
      end
      tick();
    end
    bus.dmemREN = 1'b0;
    repeat (LAT + 3) tick();
    checks++; if (second - first !== LAT + 2) begin failures++; $display("FAIL b2b_spacing got=%0d exp=%0d", second - first, LAT + 2); end
  endtask

  task automatic test_midop_reset();
    int          lat, hits;
    logic [31:0] ld;
    data_txn(1'b1, 1'b0, 32'h80, 32'hCAFE_F00D, lat, ld);
    data_txn(1'b0, 1'b0, 32'h40, 32'd0, lat, ld);
    bus.dmemWEN   = 1'b1;
    bus.dmemaddr  = 32'h80;
    bus.dmemstore = 32'h0000_1234;
    tick();
    bus.dmemWEN = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    checks++; if (bus.dmemload !== 32'd0) begin failures++; $display("FAIL midrst_dmemload got=%h exp=0", bus.dmemload); end
    checks++; if (bus.imemload !== 32'd0) begin failures++; $display("FAIL midrst_imemload got=%h exp=0", bus.imemload); end
    hits = 0;
    repeat (8) begin
      if (bus.dhit === 1'b1) hits++;
      tick();
    end
    checks++; if (hits !== 0) begin failures++; $display("FAIL midrst_no_dhit got=%0d exp=0", hits); end
    data_txn(1'b0, 1'b0, 32'h80, 32'd0, lat, ld);
    checks++; if (ld !== 32'hCAFE_F00D) begin failures++; $display("FAIL midrst_old_value got=%h exp=cafef00d", ld); end
  endtask

  task automatic test_halt();
    int          d_at, ihits;
    logic [31:0] dl;
    d_at  = -1;
    ihits = 0;
    dl    = 32'hx;
    bus.halt     = 1'b1;
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0;
    bus.dmemREN  = 1'b1;
    bus.dmemaddr = 32'h40;
    tick();
    bus.dmemREN = 1'b0;
    checks++; if (bus.flushed !== 1'b0) begin failures++; $display("FAIL halt_flushed_early got=%b exp=0", bus.flushed); end
    for (int n = 1; n <= 12; n++) begin
      if (bus.dhit === 1'b1 && d_at < 0) begin d_at = n; dl = bus.dmemload; end
      if (bus.ihit === 1'b1) ihits++;
      tick();
    end
    checks++; if (d_at !== LAT + 1) begin failures++; $display("FAIL halt_data_served got=%0d exp=%0d", d_at, LAT + 1); end
    checks++; if (dl !== 32'hDEADBEEF) begin failures++; $display("FAIL halt_data_value got=%h exp=deadbeef", dl); end
    checks++; if (ihits !== 0) begin failures++; $display("FAIL halt_no_fetch got=%0d exp=0", ihits); end
    checks++; if (bus.flushed !== 1'b1) begin failures++; $display("FAIL halt_flushed got=%b exp=1", bus.flushed); end
    bus.imemREN = 1'b0;
    bus.halt    = 1'b0;
    repeat (3) tick();
    checks++; if (bus.flushed !== 1'b1) begin failures++; $display("FAIL flushed_sticky got=%b exp=1", bus.flushed); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.flushed !== 1'b0) begin failures++; $display("FAIL flushed_reset got=%b exp=0", bus.flushed); end
  endtask

  task automatic test_llsc();
    int          lat;
    logic [31:0] ld;
`ifdef DP_MEM_LLSC_EN
    data_txn(1'b0, 1'b1, 32'h100, 32'd0, lat, ld);
    data_txn(1'b1, 1'b1, 32'h100, 32'd7, lat, ld);
    checks++; if (ld !== 32'd1) begin failures++; $display("FAIL sc_success got=%h exp=1", ld); end
    data_txn(1'b0, 1'b0, 32'h100, 32'd0, lat, ld);
    checks++; if (ld !== 32'd7) begin failures++; $display("FAIL sc_word got=%h exp=7", ld); end
    data_txn(1'b0, 1'b1, 32'h100, 32'd0, lat, ld);
    data_txn(1'b1, 1'b0, 32'h100, 32'd9, lat, ld);
    data_txn(1'b1, 1'b1, 32'h100, 32'h55, lat, ld);
    checks++; if (ld !== 32'd0) begin failures++; $display("FAIL sc_fail got=%h exp=0", ld); end
    data_txn(1'b0, 1'b0, 32'h100, 32'd0, lat, ld);
    checks++; if (ld !== 32'd9) begin failures++; $display("FAIL sc_fail_word got=%h exp=9", ld); end
`else
    data_txn(1'b1, 1'b1, 32'h100, 32'd7, lat, ld);
    checks++; if (ld !== 32'd0) begin failures++; $display("FAIL atomic_ignored_load got=%h exp=0", ld); end
    data_txn(1'b0, 1'b1, 32'h100, 32'd0, lat, ld);
    checks++; if (ld !== 32'd7) begin failures++; $display("FAIL atomic_ignored_word got=%h exp=7", ld); end
`endif
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    overlaps = 0;
    rst      = 1'b1;
    idle_inputs();
    test_reset();
    test_write_fetch();
    test_priority();
    test_no_preempt();
    test_back_to_back();
    test_midop_reset();
    test_halt();
    test_llsc();
    checks++; if (overlaps !== 0) begin failures++; $display("FAIL hit_overlap got=%0d exp=0", overlaps); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dp_mem_responder.md
# dp_mem_responder

Memory-side responder for the datapath cache interface. It accepts instruction fetches (`imemREN`) and data loads/stores (`dmemREN`/`dmemWEN`) from the pipeline and serves them from one single-ported word memory with a fixed, configurable latency. It returns `ihit`/`dhit` and the load data, and tracks `halt` to report `flushed`. It sits between the datapath and the backing store, in place of the cache hierarchy, for pipeline bring-up and verification.

## Interface
- `DEPTH_WORDS`, 1024: memory size in 32-bit words; power of two.
- `LAT`, 2: wait cycles between acceptance and response; legal range 1..15.
- `CLK`  in  1  clock; all state changes on the rising edge.
- `RST`  in  1  reset; **synchronous, active-high**.
- `imemREN`  in  1  instruction read request.
- `imemaddr`  in  32  instruction byte address.
- `ihit`  out  1  instruction response strobe.
- `imemload`  out  32  instruction word.
- `dmemREN`  in  1  data read request.
- `dmemWEN`  in  1  data write request.
- `datomic`  in  1  the current data access is LL (read) or SC (write).
- `dmemaddr`  in  32  data byte address.
- `dmemstore`  in  32  store data.
- `dhit`  out  1  data response strobe.
- `dmemload`  out  32  load data, or the SC result.
- `halt`  in  1  datapath halted.
- `flushed`  out  1  sticky; halted and no access outstanding.

## Operation
- Word index is `addr[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so addresses alias modulo the memory size. `addr[1:0]` is ignored.
- FSM states: IDLE, IWAIT, DWAIT, IRESP, DRESP.
- IDLE:
  - If `dmemREN|dmemWEN`, latch address, store data, read/write kind and `datomic`, then go to DWAIT.
  - Otherwise, if `imemREN`, latch `imemaddr` and go to IWAIT.
  - Data always has priority over instruction.
- On entering either WAIT state, the counter is loaded with `LAT-1`. It decrements each cycle. At 0 the FSM moves to the matching RESP state.
- The memory access happens on the WAIT→RESP edge.
  - Read: the word is registered into `imemload` or `dmemload`.
  - Write: the array is updated; `dmemload` is set to 0.
- In IRESP `ihit`=1, and in DRESP `dhit`=1, each for exactly one cycle. The next state is IDLE.
- A transaction in progress is never aborted or pre-empted. A data request that arrives during IWAIT waits for IRESP to finish, then is accepted on the next IDLE cycle.
- Request inputs are sampled only in IDLE. Changes during WAIT or RESP are ignored.
- `halt`:
  - While `halt`=1, IDLE accepts no new instruction requests. Data requests are still served.
  - `flushed` is set on the edge where the FSM is in IDLE with `halt`=1 and no data request is present.
  - `flushed` stays set until `RST`.

## Timing
- Request present in IDLE during cycle t → hit high during cycle t+LAT+1. Load data is valid in that same cycle and holds until the next access of its port.
- Back-to-back throughput is one transaction every LAT+2 cycles.
- `ihit` and `dhit` are never high in the same cycle.
- `RST` sampled high:
  - state goes to IDLE; counter to 0;
  - `ihit`, `dhit`, `flushed` go to 0; `imemload` and `dmemload` go to 0;
  - the LL link is cleared.
- Memory contents are not cleared by reset.
- Reset during WAIT abandons the transaction. A pending write is not performed.
- A write and an instruction fetch to the same word, served sequentially, return the newly written word.

## Configuration
- `DP_MEM_LLSC_EN` defined: load-linked/store-conditional support.
  - A read with `datomic`=1 sets link = {valid, word index}.
  - A write with `datomic`=1 writes only if the link is valid and the index matches. `dmemload`=1 on success, 0 on failure. The link is cleared either way.
  - Any non-atomic write to the linked index clears the link.
- Not defined: `datomic` is ignored. All writes are unconditional and `dmemload`=0 on writes.

## Test plan
- Reset: hold `RST`=1 for 2 cycles with all requests active → `ihit`=`dhit`=`flushed`=0 and loads=0. With LAT=2, the first `imemREN` after release gets `ihit` exactly 3 cycles later.
- Write then fetch: `dmemWEN` to 0x40 with data 0xDEADBEEF → `dhit` after LAT+1 cycles. Then `imemREN` at 0x40 → `imemload`=0xDEADBEEF. The same fetch at 0x40+4*DEPTH_WORDS returns the same word (aliasing).
- Priority: `imemREN`@0x0 and `dmemREN`@0x40 asserted together in IDLE → `dhit` first. `ihit` follows LAT+2 cycles later; the two strobes never overlap.
- No pre-emption: `dmemWEN` raised one cycle into IWAIT → `ihit` first, then `dhit`. The write does not occur before `ihit`.
- Mid-op reset: `dmemWEN` to 0x80 with 0x1234; `RST` pulsed during DWAIT → no `dhit`. A later read of 0x80 returns the old value.
- Halt/LLSC: `halt`=1 with no data request → `flushed`=1 on the next cycle, sticky. With `DP_MEM_LLSC_EN`:
  - LL 0x100, then SC 0x100 with 7 → `dmemload`=1 and the word = 7.
  - LL 0x100, plain SW 0x100, then SC → `dmemload`=0 and the word is unchanged by the SC.
